// File: rtl/alu_share_arbiter_if.sv
// Bundle of the requester, ALU and response signals around alu_share_arbiter.
// slave = arbiter side, master = requesters / ALU / response consumer side.
interface alu_share_arbiter_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int CONTROL_WIDTH = 3
);
  logic [1:0]               req_valid;
  logic [1:0]               req_ready;
  logic [DATA_WIDTH-1:0]    req0_op1;
  logic [DATA_WIDTH-1:0]    req0_op2;
  logic [CONTROL_WIDTH-1:0] req0_ctrl;
  logic [DATA_WIDTH-1:0]    req1_op1;
  logic [DATA_WIDTH-1:0]    req1_op2;
  logic [CONTROL_WIDTH-1:0] req1_ctrl;
  logic [DATA_WIDTH-1:0]    alu_op1;
  logic [DATA_WIDTH-1:0]    alu_op2;
  logic [CONTROL_WIDTH-1:0] alu_ctrl;
  logic [DATA_WIDTH-1:0]    alu_out;
  logic                     alu_zero;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic                     rsp_id;
  logic [DATA_WIDTH-1:0]    rsp_data;
  logic                     rsp_zero;
  logic                     busy;

  modport slave (
    input  req_valid, req0_op1, req0_op2, req0_ctrl, req1_op1, req1_op2, req1_ctrl,
    input  alu_out, alu_zero, rsp_ready,
    output req_ready, alu_op1, alu_op2, alu_ctrl,
    output rsp_valid, rsp_id, rsp_data, rsp_zero, busy
  );

  modport master (
    output req_valid, req0_op1, req0_op2, req0_ctrl, req1_op1, req1_op2, req1_ctrl,
    output alu_out, alu_zero, rsp_ready,
    input  req_ready, alu_op1, alu_op2, alu_ctrl,
    input  rsp_valid, rsp_id, rsp_data, rsp_zero, busy
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational ALU between two requesters.
// One op in flight: IDLE (grant) -> EXEC (ALU evaluates) -> HOLD (response until taken).
module alu_share_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int CONTROL_WIDTH = 3
) (
  input  logic                clk,
  input  logic                rst,
  alu_share_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  state_t                   state_reg, state_next;
  logic                     rr_ptr_reg;
  logic                     gnt_id_reg;
  logic [DATA_WIDTH-1:0]    alu_op1_reg, alu_op2_reg;
  logic [CONTROL_WIDTH-1:0] alu_ctrl_reg;
  logic                     rsp_valid_reg, rsp_id_reg, rsp_zero_reg;
  logic [DATA_WIDTH-1:0]    rsp_data_reg;

  logic                     grant_vld;
  logic                     grant_id;
  logic [1:0]               ready_vec;
  logic [DATA_WIDTH-1:0]    op1_arr  [2];
  logic [DATA_WIDTH-1:0]    op2_arr  [2];
  logic [CONTROL_WIDTH-1:0] ctrl_arr [2];

  assign op1_arr[0]  = bus.req0_op1;
  assign op2_arr[0]  = bus.req0_op2;
  assign ctrl_arr[0] = bus.req0_ctrl;
  assign op1_arr[1]  = bus.req1_op1;
  assign op2_arr[1]  = bus.req1_op2;
  assign ctrl_arr[1] = bus.req1_ctrl;

  // Grant only while idle and out of reset; rr_ptr only breaks ties.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = 1'b0;
    if (state_reg == IDLE && !rst) begin
      case (bus.req_valid)
        2'b11: begin grant_vld = 1'b1; grant_id = rr_ptr_reg; end
        2'b01: begin grant_vld = 1'b1; grant_id = 1'b0;       end
        2'b10: begin grant_vld = 1'b1; grant_id = 1'b1;       end
        default: ;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ready
      assign ready_vec[gi] = grant_vld && (grant_id == 1'(gi));
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant_vld) state_next = EXEC;
      EXEC:    state_next = HOLD;
      HOLD:    if (bus.rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      rr_ptr_reg    <= 1'b0;
      gnt_id_reg    <= 1'b0;
      alu_op1_reg   <= '0;
      alu_op2_reg   <= '0;
      alu_ctrl_reg  <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_id_reg    <= 1'b0;
      rsp_data_reg  <= '0;
      rsp_zero_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (grant_vld) begin
        alu_op1_reg  <= op1_arr[grant_id];
        alu_op2_reg  <= op2_arr[grant_id];
        alu_ctrl_reg <= ctrl_arr[grant_id];
        gnt_id_reg   <= grant_id;
        rr_ptr_reg   <= ~grant_id;
      end
      if (state_reg == EXEC) begin
        rsp_data_reg  <= bus.alu_out;
        rsp_zero_reg  <= bus.alu_zero;
        rsp_id_reg    <= gnt_id_reg;
        rsp_valid_reg <= 1'b1;
      end
      if (state_reg == HOLD && bus.rsp_ready) begin
        rsp_valid_reg <= 1'b0;
      end
    end
  end

  assign bus.req_ready = ready_vec;
  assign bus.alu_op1   = alu_op1_reg;
  assign bus.alu_op2   = alu_op2_reg;
  assign bus.alu_ctrl  = alu_ctrl_reg;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_id    = rsp_id_reg;
  assign bus.rsp_data  = rsp_data_reg;
  assign bus.rsp_zero  = rsp_zero_reg;
  assign bus.busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: behavioural ALU on the alu_* side, scoreboard on responses.
module tb_alu_share_arbiter;
  localparam int DW = 32;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_share_arbiter_if #(.DATA_WIDTH(DW), .CONTROL_WIDTH(CW)) bus ();

  alu_share_arbiter #(.DATA_WIDTH(DW), .CONTROL_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct packed {
    logic          id;
    logic [DW-1:0] data;
    logic          zero;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t mon_e;

  function automatic logic [DW-1:0] ref_alu(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [CW-1:0] c);
    case (c)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return '0;
    endcase
  endfunction

  assign bus.alu_out  = ref_alu(bus.alu_op1, bus.alu_op2, bus.alu_ctrl);
  assign bus.alu_zero = (bus.alu_out == '0);

  always @(posedge clk) cyc <= cyc + 1;

  // Accepted requests push the expected response; accepted responses pop and compare.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        if (bus.req_valid[k] && bus.req_ready[k]) begin
          mon_e.id   = (k == 1);
          mon_e.data = (k == 1) ? ref_alu(bus.req1_op1, bus.req1_op2, bus.req1_ctrl)
                                : ref_alu(bus.req0_op1, bus.req0_op2, bus.req0_ctrl);
          mon_e.zero = (mon_e.data == '0);
          exp_q.push_back(mon_e);
          $display("cyc %0d accept req%0d expect data=%h", cyc, k, mon_e.data);
        end
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL rsp_unexpected: got id=%0d data=%h, required no response",
                   bus.rsp_id, bus.rsp_data);
        end else begin
          mon_e = exp_q.pop_front();
          if (bus.rsp_id !== mon_e.id || bus.rsp_data !== mon_e.data || bus.rsp_zero !== mon_e.zero) begin
            bad++;
            $display("FAIL rsp_scoreboard: got id=%0d data=%h zero=%0d, required id=%0d data=%h zero=%0d",
                     bus.rsp_id, bus.rsp_data, bus.rsp_zero, mon_e.id, mon_e.data, mon_e.zero);
          end else begin
            $display("cyc %0d response id=%0d data=%h zero=%0d ok", cyc, bus.rsp_id, bus.rsp_data, bus.rsp_zero);
          end
        end
      end
    end
  end

  task automatic test_reset;
    rst = 1'b1;
    bus.req_valid = 2'b11;
    bus.rsp_ready = 1'b0;
    bus.req0_op1 = 32'h11; bus.req0_op2 = 32'h22; bus.req0_ctrl = 3'd0;
    bus.req1_op1 = 32'h33; bus.req1_op2 = 32'h44; bus.req1_ctrl = 3'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (bus.req_ready !== 2'b00) begin
      bad++; $display("FAIL reset_ready_in_rst: got %b, required 00", bus.req_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.req_valid = 2'b00;
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b, required 0", bus.busy); end
    total++;
    if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b, required 0", bus.rsp_valid); end
    total++;
    if (bus.alu_op1 !== '0 || bus.alu_op2 !== '0 || bus.alu_ctrl !== '0) begin
      bad++; $display("FAIL reset_alu_regs: got %h %h %0d, required 0 0 0", bus.alu_op1, bus.alu_op2, bus.alu_ctrl);
    end
    total++;
    if (bus.req_ready !== 2'b00) begin bad++; $display("FAIL reset_ready: got %b, required 00", bus.req_ready); end
    $display("test_reset complete");
  endtask

  task automatic test_single;
    @(posedge clk); #1;
    bus.req_valid = 2'b01;
    bus.req0_op1 = 32'd5; bus.req0_op2 = 32'd3; bus.req0_ctrl = 3'd0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    total++;
    if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL single_ready: got %b, required 01", bus.req_ready); end
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    @(negedge clk);
    total++;
    if (bus.alu_op1 !== 32'd5 || bus.alu_op2 !== 32'd3 || bus.alu_ctrl !== 3'd0) begin
      bad++; $display("FAIL single_alu_regs: got %h %h %0d, required 5 3 0", bus.alu_op1, bus.alu_op2, bus.alu_ctrl);
    end
    total++;
    if (bus.busy !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.req_ready !== 2'b00) begin
      bad++; $display("FAIL single_exec: got busy=%b rsp_valid=%b ready=%b, required 1 0 00",
                      bus.busy, bus.rsp_valid, bus.req_ready);
    end
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'd8 || bus.rsp_id !== 1'b0 || bus.rsp_zero !== 1'b0) begin
      bad++; $display("FAIL single_rsp: got valid=%b data=%h id=%b zero=%b, required 1 8 0 0",
                      bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.rsp_zero);
    end
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      bad++; $display("FAIL single_idle: got busy=%b rsp_valid=%b, required 0 0", bus.busy, bus.rsp_valid);
    end
    total++;
    if (bus.alu_op1 !== 32'd5) begin bad++; $display("FAIL single_op_kept: got %h, required 5", bus.alu_op1); end
    $display("test_single complete");
  endtask

  task automatic test_contention;
    logic exp_id;
    int   grants;
    @(posedge clk); #1;
    rst = 1'b1;
    bus.req_valid = 2'b00;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.req0_op1 = 32'd10; bus.req0_op2 = 32'd4; bus.req0_ctrl = 3'd0;
    bus.req1_op1 = 32'd7;  bus.req1_op2 = 32'd7; bus.req1_ctrl = 3'd1;
    bus.req_valid = 2'b11;
    bus.rsp_ready = 1'b1;
    exp_id = 1'b0;
    grants = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.req_ready !== 2'b00) begin
        total++;
        if (bus.req_ready !== (2'b01 << exp_id)) begin
          bad++; $display("FAIL contention_grant: got %b, required %b", bus.req_ready, 2'b01 << exp_id);
        end
        exp_id = ~exp_id;
        grants++;
      end
      @(posedge clk); #1;
    end
    bus.req_valid = 2'b00;
    total++;
    if (grants !== 4) begin bad++; $display("FAIL contention_count: got %0d grants, required 4", grants); end
    $display("test_contention complete");
  endtask

  task automatic test_backpressure;
    @(posedge clk); #1;
    bus.req_valid = 2'b01;
    bus.req0_op1 = 32'hdeadbeef; bus.req0_op2 = 32'h0000ffff; bus.req0_ctrl = 3'd2;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    total++;
    if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL bp_ready: got %b, required 01", bus.req_ready); end
    @(posedge clk); #1;
    bus.req_valid = 2'b11;
    @(negedge clk);
    total++;
    if (bus.req_ready !== 2'b00 || bus.rsp_valid !== 1'b0) begin
      bad++; $display("FAIL bp_exec: got ready=%b rsp_valid=%b, required 00 0", bus.req_ready, bus.rsp_valid);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      total++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h0000beef || bus.rsp_id !== 1'b0 ||
          bus.rsp_zero !== 1'b0 || bus.req_ready !== 2'b00 || bus.busy !== 1'b1) begin
        bad++;
        $display("FAIL bp_hold[%0d]: got valid=%b data=%h id=%b zero=%b ready=%b busy=%b, required 1 0000beef 0 0 00 1",
                 i, bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.rsp_zero, bus.req_ready, bus.busy);
      end
    end
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      bad++; $display("FAIL bp_release: got busy=%b rsp_valid=%b, required 0 0", bus.busy, bus.rsp_valid);
    end
    $display("test_backpressure complete");
  endtask

  task automatic test_reset_mid;
    @(posedge clk); #1;
    bus.req_valid = 2'b01;
    bus.req0_op1 = 32'd1; bus.req0_op2 = 32'd2; bus.req0_ctrl = 3'd0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    total++;
    if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL midrst_ready: got %b, required 01", bus.req_ready); end
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      bad++; $display("FAIL midrst_idle: got busy=%b rsp_valid=%b, required 0 0", bus.busy, bus.rsp_valid);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      total++;
      if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL midrst_no_rsp[%0d]: got %b, required 0", i, bus.rsp_valid); end
    end
    @(posedge clk); #1;
    bus.req1_op1 = 32'd9; bus.req1_op2 = 32'd6; bus.req1_ctrl = 3'd4;
    bus.req_valid = 2'b11;
    @(negedge clk);
    total++;
    if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL midrst_rr: got %b, required 01", bus.req_ready); end
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    $display("test_reset_mid complete");
  endtask

  task automatic test_lone;
    int grants;
    int last;
    @(posedge clk); #1;
    bus.req_valid = 2'b10;
    bus.req1_op1 = 32'd100; bus.req1_op2 = 32'd58; bus.req1_ctrl = 3'd1;
    bus.rsp_ready = 1'b1;
    grants = 0;
    last = 0;
    for (int c = 0; c < 12 && grants < 3; c++) begin
      @(negedge clk);
      if (bus.req_ready !== 2'b00) begin
        total++;
        if (bus.req_ready !== 2'b10) begin bad++; $display("FAIL lone_grant: got %b, required 10", bus.req_ready); end
        if (grants > 0) begin
          total++;
          if (cyc - last !== 3) begin bad++; $display("FAIL lone_spacing: got %0d cycles, required 3", cyc - last); end
        end
        last = cyc;
        grants++;
      end
      @(posedge clk); #1;
      if (grants == 3) bus.req_valid = 2'b00;
      else if (bus.busy) bus.req1_op1 = bus.req1_op1 + 32'd1;
    end
    bus.req_valid = 2'b00;
    total++;
    if (grants !== 3) begin bad++; $display("FAIL lone_count: got %0d grants, required 3", grants); end
    repeat (4) @(posedge clk);
    #1;
    $display("test_lone complete");
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b0;
    bus.req0_op1 = '0; bus.req0_op2 = '0; bus.req0_ctrl = '0;
    bus.req1_op1 = '0; bus.req1_op2 = '0; bus.req1_ctrl = '0;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_reset_mid();
    test_lone();
    @(negedge clk);
    total++;
    if (exp_q.size() !== 0) begin
      bad++; $display("FAIL scoreboard_leftover: got %0d pending, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
